// File: rtl/param_frame_tx.sv
// param_frame_tx: sends four data bytes (LSB first) and a control byte over a byte-level UART,
// then waits for the checksum reply and reports ok, error or timeout.
module param_frame_tx #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2010000,
    parameter logic [7:0]  NOCHK_CTRL     = 8'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  ctrl_in,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        ack_ok,
    output logic        ack_err,
    output logic        timed_out,
    output logic [7:0]  rsp_byte,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        is_transmitting,
    input  logic        received,
    input  logic [7:0]  rx_byte
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, WAIT_ACK, DONE} state_t;
    state_t      state, state_nx;
    logic [31:0] data_q, timer;
    logic [7:0]  ctrl_q, chk;
    logic [2:0]  idx;
    logic [2:0]  res;
    logic        expired;

    assign expired = timer == TIMEOUT_CYCLES - 32'd1;

    always_comb begin
        state_nx  = state;
        busy      = state != IDLE && state != DONE;
        done      = state == DONE;
        transmit  = state == SEND && !is_transmitting;
        tx_byte   = idx[2] ? ctrl_q : data_q[8*idx[1:0] +: 8];
        ack_ok    = done && res[0];
        ack_err   = done && res[1];
        timed_out = done && res[2];
        case (state)
            IDLE:     if (start) state_nx = SEND;
            SEND:     if (!is_transmitting) state_nx = WAIT_HI;
            WAIT_HI:  if (is_transmitting) state_nx = WAIT_LO;
            WAIT_LO:  if (!is_transmitting) state_nx = idx == 3'd4 ? WAIT_ACK : SEND;
            WAIT_ACK: if (received || expired) state_nx = DONE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            ctrl_q   <= '0;
            chk      <= '0;
            idx      <= '0;
            timer    <= '0;
            rsp_byte <= '0;
            res      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                data_q <= data_in;
                ctrl_q <= ctrl_in;
                chk    <= data_in[7:0] + data_in[15:8] + data_in[23:16] + data_in[31:24];
                idx    <= '0;
            end
            if (state == WAIT_LO && !is_transmitting) begin
                if (idx != 3'd4) idx <= idx + 3'd1;
                timer <= '0;
            end
            // A reply arriving on the expiry cycle still counts as a reply.
            if (state == WAIT_ACK) begin
                timer <= timer + 32'd1;
                if (received) begin
                    rsp_byte <= rx_byte;
                    res      <= (rx_byte == chk || ctrl_q == NOCHK_CTRL) ? 3'b001 : 3'b010;
                end else if (expired) begin
                    res <= 3'b100;
                end
            end
        end
    end
endmodule

// File: tb/tb_param_frame_tx.sv
// tb_param_frame_tx: directed and random transactions against a byte-level UART/responder model.
module tb_param_frame_tx;
    logic        clk = 0, rst = 1, start = 0, is_transmitting = 0, received = 0;
    logic [7:0]  ctrl_in = 0, rx_byte = 0;
    logic [31:0] data_in = 0;
    logic        busy, done, ack_ok, ack_err, timed_out, transmit;
    logic [7:0]  rsp_byte, tx_byte;
    int          errors = 0, checks = 0, byte_t = 3;
    logic [7:0]  last_rsp = 0;
    bit          ab;

    param_frame_tx #(.TIMEOUT_CYCLES(32'd100), .NOCHK_CTRL(8'd2)) dut (
        .clk(clk), .rst(rst), .start(start), .ctrl_in(ctrl_in), .data_in(data_in),
        .busy(busy), .done(done), .ack_ok(ack_ok), .ack_err(ack_err), .timed_out(timed_out),
        .rsp_byte(rsp_byte), .transmit(transmit), .tx_byte(tx_byte),
        .is_transmitting(is_transmitting), .received(received), .rx_byte(rx_byte)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_sum(input logic [31:0] d);
        int s = 0;
        for (int i = 0; i < 4; i++) s += (d >> (8 * i)) & 255;
        return 8'(s % 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ok"}, ack_ok, 0);
        check({tag, "_err"}, ack_err, 0);
        check({tag, "_to"}, timed_out, 0);
        check({tag, "_transmit"}, transmit, 0);
    endtask

    task automatic do_start(input logic [31:0] d, input logic [7:0] c);
        @(posedge clk); #1;
        data_in = d; ctrl_in = c; start = 1;
        @(posedge clk); #1;
        start = 0; data_in = $urandom; ctrl_in = 8'($urandom);
        @(negedge clk);
        check("busy_after_start", busy, 1);
    endtask

    task automatic serve(input logic [31:0] d, input logic [7:0] c, input int rst_at, input bit stray,
                         output bit aborted);
        aborted = 0;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] eb;
            int n;
            eb = (i < 4) ? 8'(d >> (8 * i)) : c;
            n = 0;
            while (!transmit && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("tx_strobe_seen", n < 50, 1);
            check($sformatf("tx_byte%0d", i), tx_byte, eb);
            if (stray && i == 0) begin
                start = 1; data_in = ~d; ctrl_in = c ^ 8'd1;
                received = 1; rx_byte = 8'hEE;
            end
            @(posedge clk); #1;
            is_transmitting = 1; start = 0; received = 0;
            @(negedge clk);
            check("strobe_one_cycle", transmit, 0);
            if (stray && i == 0) check("stray_rsp_kept", rsp_byte, last_rsp);
            if (i == rst_at) begin
                @(posedge clk); #1 rst = 1;
                @(posedge clk); #1 rst = 0; is_transmitting = 0;
                check_quiet("midreset");
                check("midreset_tx_byte", tx_byte, 0);
                check("midreset_rsp", rsp_byte, 0);
                last_rsp = 0;
                aborted = 1;
                return;
            end
            repeat (byte_t) begin
                @(negedge clk);
                check("tx_byte_stable", tx_byte, eb);
            end
            @(posedge clk); #1 is_transmitting = 0;
        end
    endtask

    task automatic finish_reply(input logic [31:0] d, input logic [7:0] c, input logic [7:0] r, input int dly);
        bit ok;
        ok = (r == ref_sum(d)) || (c == 8'd2);
        @(posedge clk);
        repeat (dly) @(posedge clk);
        #1 received = 1; rx_byte = r;
        @(posedge clk); #1 received = 0; rx_byte = 8'($urandom);
        @(negedge clk);
        check("done", done, 1);
        check("ack_ok", ack_ok, ok);
        check("ack_err", ack_err, !ok);
        check("timed_out", timed_out, 0);
        check("rsp_byte", rsp_byte, r);
        check("busy_in_done", busy, 0);
        last_rsp = r;
        @(negedge clk);
        check_quiet("after_done");
    endtask

    task automatic finish_timeout();
        int n = 0;
        @(posedge clk);
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done && n < 300);
        check("timeout_latency", n, 100);
        check("to_flag", timed_out, 1);
        check("to_ok", ack_ok, 0);
        check("to_err", ack_err, 0);
        check("to_rsp_kept", rsp_byte, last_rsp);
        @(negedge clk);
        check_quiet("after_timeout");
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  c, r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_tx_byte", tx_byte, 0);
        check("reset_rsp", rsp_byte, 0);
        #1 rst = 0;

        do_start(32'd201000, 8'd1); serve(32'd201000, 8'd1, -1, 0, ab); finish_reply(32'd201000, 8'd1, 8'h3C, 0);
        do_start(32'h01020304, 8'd0); serve(32'h01020304, 8'd0, -1, 0, ab); finish_reply(32'h01020304, 8'd0, 8'h0B, 2);
        do_start(32'h01020304, 8'd0); serve(32'h01020304, 8'd0, -1, 0, ab); finish_reply(32'h01020304, 8'd0, 8'h0A, 1);
        do_start(32'h000000FF, 8'd2); serve(32'h000000FF, 8'd2, -1, 0, ab); finish_reply(32'h000000FF, 8'd2, 8'h55, 3);

        d = $urandom; byte_t = 2;
        do_start(d, 8'd5); serve(d, 8'd5, -1, 0, ab); finish_timeout();

        d = $urandom;
        do_start(d, 8'd3); serve(d, 8'd3, 2, 0, ab);
        check("reset_aborted", ab, 1);
        d = $urandom;
        do_start(d, 8'd6); serve(d, 8'd6, -1, 0, ab); finish_reply(d, 8'd6, ref_sum(d), 0);

        byte_t = 3;
        do_start(32'd201000, 8'd1); serve(32'd201000, 8'd1, -1, 1, ab); finish_reply(32'd201000, 8'd1, 8'h3C, 1);

        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            c = 8'($urandom_range(0, 6));
            r = $urandom_range(0, 1) ? ref_sum(d) : 8'($urandom);
            byte_t = $urandom_range(1, 5);
            do_start(d, c); serve(d, c, -1, 0, ab); finish_reply(d, c, r, $urandom_range(0, 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
